row_skew_feeder: RTL and testbench

- Sits directly downstream of the ARR_SIZE per-row FIFO buffers and directly upstream of the systolic array's west edge.
- Accepts one row-parallel vector per cycle (one 16-bit word per row) and emits it diagonally skewed: row r is delayed r cycles, giving the wavefront timing the PE grid requires.
- Owns a small FEED/FLUSH state machine that counts a programmed number of vectors, inserts zero bubbles, and pulses done once the last word has left the last row.

---
 rtl/row_skew_feeder.sv | 171 +++++++++++++++++
 tb/tb_row_skew_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_skew_feeder.sv
// -----------------------------------------------------------------------------
// row_skew_feeder
//
// Purpose:
//   Takes one row-parallel vector per cycle from the per-row FIFO buffers and
//   re-times it into the diagonal wavefront that the systolic array's west edge
//   expects: row r is delayed r cycles relative to row 0.  A small
//   IDLE/FEED/FLUSH controller counts a programmed number of vectors. It lets
//   the lanes drain after the last vector and pulses done once every lane is
//   empty again.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle job start, honoured in IDLE only
//   num_vectors  in   vectors in the job, latched on an accepted start
//   in_data      in   row words, row r at [r*DATA_W +: DATA_W]
//   in_valid     in   in_data holds a vector this cycle
//   in_ready     out  feeder takes a vector this cycle (FEED state)
//   skew_data    out  skewed row words, same lane packing as in_data
//   skew_valid   out  per-row valid for skew_data
//   busy         out  job in progress (FEED or FLUSH)
//   done         out  one-cycle pulse at job end
//   stall_cycles out  (FEEDER_STALL_CNT_EN only) FEED cycles without a vector
//
// Build option:
//   FEEDER_STALL_CNT_EN - adds the saturating stall_cycles counter and port.
// -----------------------------------------------------------------------------
module row_skew_feeder #(
   parameter int ARR_SIZE = 4,
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [CNT_W-1:0]           num_vectors,
   input  logic [ARR_SIZE*DATA_W-1:0] in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [ARR_SIZE*DATA_W-1:0] skew_data,
   output logic [ARR_SIZE-1:0]        skew_valid,
   output logic                       busy,
   output logic                       done
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]           stall_cycles
`endif
);

   localparam int FL_W = $clog2(ARR_SIZE + 1);
   localparam logic [FL_W-1:0] FLUSH_INIT = FL_W'(ARR_SIZE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [FL_W-1:0]   flush_q, flush_d;
   logic              accept;

   assign in_ready = (state_q == S_FEED);
   assign accept   = in_ready && in_valid;
   assign busy     = (state_q != S_IDLE);
   // The flush count is loaded with ARR_SIZE on the last accept, so it hits
   // zero exactly one cycle after the last row's word has been presented.
   assign done     = (state_q == S_FLUSH) && (flush_q == '0);

   // ---- control: state register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         remain_q <= '0;
         flush_q  <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         flush_q  <= flush_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      flush_d  = flush_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_vectors != '0) begin
                  remain_d = num_vectors;
                  state_d  = S_FEED;
               end else begin
                  // Empty job: nothing enters the lanes, so done follows at once.
                  flush_d = '0;
                  state_d = S_FLUSH;
               end
            end
         end
         S_FEED: begin
            if (accept) begin
               remain_d = remain_q - CNT_W'(1);
               if (remain_q == CNT_W'(1)) begin
                  flush_d = FLUSH_INIT;
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (flush_q == '0) begin
               state_d = S_IDLE;
            end else begin
               flush_d = flush_q - FL_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- datapath: per-row delay lanes, depth r+1, last stage drives output ----
   for (genvar r = 0; r < ARR_SIZE; r++) begin : g_lane
      localparam int LW  = r + 1;
      localparam int LDW = LW * DATA_W;

      logic [LDW-1:0]    lane_dat_q;
      logic [LW-1:0]     lane_vld_q;
      logic [DATA_W-1:0] feed_dat;

      // Non-accepted cycles (bubbles, IDLE, FLUSH) shift in zero data so an
      // invalid lane never shows a stale word.
      assign feed_dat = accept ? in_data[r*DATA_W +: DATA_W] : '0;

      always_ff @(posedge clk) begin
         if (rst) begin
            lane_dat_q <= '0;
            lane_vld_q <= '0;
         end else begin
            lane_dat_q <= (lane_dat_q << DATA_W) | LDW'(feed_dat);
            lane_vld_q <= (lane_vld_q << 1) | LW'(accept);
         end
      end

      assign skew_data[r*DATA_W +: DATA_W] = lane_dat_q[r*DATA_W +: DATA_W];
      assign skew_valid[r]                 = lane_vld_q[r];
   end

`ifdef FEEDER_STALL_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] stall_q;
   logic             start_acc;

   assign start_acc = (state_q == S_IDLE) && start;

   // ---- control: stall counter ----
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         stall_q <= '0;
      end else if (in_ready && !in_valid) begin
         stall_q <= sat_inc(stall_q);
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_row_skew_feeder.sv
`timescale 1ns/1ps
module tb_row_skew_feeder;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [CW-1:0]   num_vectors;
   logic [N*DW-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] skew_data;
   logic [N-1:0]    skew_valid;
   logic            busy;
   logic            done;
`ifdef FEEDER_STALL_CNT_EN
   logic [CW-1:0]   stall_cycles;
`endif

   row_skew_feeder #(.ARR_SIZE(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_vectors (num_vectors),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .skew_data   (skew_data),
      .skew_valid  (skew_valid),
      .busy        (busy),
      .done        (done)
`ifdef FEEDER_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } exp_t;

   exp_t lane_q[N][$];
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   bit   mon_en = 1'b0;

   // Scoreboard consumer: every lane, every cycle, on the falling edge.
   exp_t          me;
   logic [DW-1:0] mw;
   always @(negedge clk) begin
      if (mon_en) begin
         for (int r = 0; r < N; r++) begin
            mw = skew_data[r*DW +: DW];
            if (skew_valid[r] === 1'b1) begin
               total++;
               if (lane_q[r].size() == 0) begin
                  bad++;
                  $display("FAIL lane%0d_extra: got valid word %h at cyc %0d, want no valid", r, mw, cyc);
               end else begin
                  me = lane_q[r].pop_front();
                  if (mw !== me.d || cyc != me.c) begin
                     bad++;
                     $display("FAIL lane%0d_word: got %h at cyc %0d, want %h at cyc %0d", r, mw, cyc, me.d, me.c);
                  end
               end
            end else begin
               total++;
               if (mw !== '0) begin
                  bad++;
                  $display("FAIL lane%0d_idle_data: got %h with valid=%b at cyc %0d, want 0000", r, mw, skew_valid[r], cyc);
               end
               if (lane_q[r].size() != 0 && lane_q[r][0].c <= cyc) begin
                  total++;
                  bad++;
                  $display("FAIL lane%0d_missing: got no valid at cyc %0d, want %h", r, cyc, lane_q[r][0].d);
                  void'(lane_q[r].pop_front());
               end
            end
         end
         if (done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by %0t, want finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [CW-1:0] n);
      start = 1'b1;
      num_vectors = n;
      tick();
      start = 1'b0;
   endtask

   // Drive one vector for one cycle; the capture edge is the next one, so
   // lane r shows it r cycles after that edge.
   task automatic drive_vec(input logic [N*DW-1:0] v);
      exp_t e;
      in_data = v;
      in_valid = 1'b1;
      for (int r = 0; r < N; r++) begin
         e.d = v[r*DW +: DW];
         e.c = cyc + 1 + r;
         lane_q[r].push_back(e);
      end
      tick();
      in_valid = 1'b0;
      in_data = '0;
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int i = 0; i < 64; i++) begin
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (skew_data !== '0) begin bad++; $display("FAIL rst_skew_data: got %h want 0", skew_data); end
      total++;
      if (skew_valid !== 4'b0000) begin bad++; $display("FAIL rst_skew_valid: got %b want 0000", skew_valid); end
      total++;
      if ({busy, done, in_ready} !== 3'b000) begin bad++; $display("FAIL rst_ctrl: got busy/done/rdy=%b want 000", {busy, done, in_ready}); end
      mon_en = 1'b1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int at, last, d0;
      d0 = done_cnt;
      start_job(8'd1);
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL single_feed_state: got busy=%b rdy=%b want 1 1", busy, in_ready); end
      drive_vec({16'h0004, 16'h0003, 16'h0002, 16'h0001});
      last = cyc;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL single_flush_rdy: got %b want 0", in_ready); end
      wait_done(at);
      total++;
      if (at != last + 4) begin bad++; $display("FAIL single_done_cyc: got %0d want %0d", at, last + 4); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_at_done: got %b want 1", busy); end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL single_after_done: got busy=%b done=%b want 0 0", busy, done); end
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
      for (int r = 0; r < N; r++) begin
         total++;
         if (lane_q[r].size() != 0) begin bad++; $display("FAIL single_lane%0d_left: got %0d pending want 0", r, lane_q[r].size()); end
      end
   endtask

   task automatic test_burst();
      int at, last, d0;
      logic [15:0] k16;
      d0 = done_cnt;
      start_job(8'd3);
      for (int k = 0; k < 3; k++) begin
         k16 = 16'(k);
         drive_vec({16'h3000 + k16, 16'h00A0 + k16, 16'h1000 + k16, 16'h0100 + k16});
      end
      last = cyc;
      wait_done(at);
      total++;
      if (at != last + 4) begin bad++; $display("FAIL burst_done_cyc: got %0d want %0d", at, last + 4); end
      tick();
      tick();
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL burst_done_count: got %0d want 1", done_cnt - d0); end
      for (int r = 0; r < N; r++) begin
         total++;
         if (lane_q[r].size() != 0) begin bad++; $display("FAIL burst_lane%0d_left: got %0d pending want 0", r, lane_q[r].size()); end
      end
   endtask

   task automatic test_bubble();
      int at, last, d0;
      d0 = done_cnt;
      start_job(8'd2);
      drive_vec({16'h4404, 16'h4403, 16'h4402, 16'h4401});
      in_valid = 1'b0;
      tick();
      drive_vec({16'h5504, 16'h5503, 16'h5502, 16'h5501});
      last = cyc;
      wait_done(at);
      total++;
      if (at != last + 4) begin bad++; $display("FAIL bubble_done_cyc: got %0d want %0d", at, last + 4); end
`ifdef FEEDER_STALL_CNT_EN
      total++;
      if (stall_cycles !== 8'd1) begin bad++; $display("FAIL bubble_stall_cnt: got %0d want 1", stall_cycles); end
`endif
      tick();
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL bubble_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_zero_job();
      int at, s, d0;
      d0 = done_cnt;
      s = cyc;
      start_job(8'd0);
      wait_done(at);
      total++;
      if (at != s + 1) begin bad++; $display("FAIL zero_done_cyc: got %0d want %0d", at, s + 1); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL zero_rdy: got %b want 0", in_ready); end
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after: got %b want 0", busy); end
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_busy_start();
      int at, last;
      start_job(8'd2);
      drive_vec({16'h6004, 16'h6003, 16'h6002, 16'h6001});
      // A second start with a larger count while feeding must be ignored.
      start = 1'b1;
      num_vectors = 8'd7;
      drive_vec({16'h7004, 16'h7003, 16'h7002, 16'h7001});
      start = 1'b0;
      last = cyc;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_start_rdy: got %b want 0", in_ready); end
      wait_done(at);
      total++;
      if (at != last + 4) begin bad++; $display("FAIL busy_start_done_cyc: got %0d want %0d", at, last + 4); end
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_job();
      int at, last, d0;
      start_job(8'd1);
      drive_vec({16'h8004, 16'h8003, 16'h8002, 16'h8001});
      tick();
      tick();
      rst = 1'b1;
      tick();
      for (int r = 0; r < N; r++) lane_q[r].delete();
      d0 = done_cnt;
      total++;
      if (skew_valid !== '0 || skew_data !== '0) begin bad++; $display("FAIL midrst_lanes: got v=%b d=%h want 0", skew_valid, skew_data); end
      total++;
      if ({busy, done, in_ready} !== 3'b000) begin bad++; $display("FAIL midrst_ctrl: got busy/done/rdy=%b want 000", {busy, done, in_ready}); end
      rst = 1'b0;
      repeat (6) tick();
      total++;
      if (done_cnt != d0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
      start_job(8'd1);
      drive_vec({16'h9004, 16'h9003, 16'h9002, 16'h9001});
      last = cyc;
      wait_done(at);
      total++;
      if (at != last + 4) begin bad++; $display("FAIL midrst_restart_done: got %0d want %0d", at, last + 4); end
      tick();
   endtask

   task automatic test_max_count();
      int at, last, d0;
      logic [15:0] w;
      d0 = done_cnt;
      start_job(8'd255);
      for (int k = 0; k < 255; k++) begin
         w = 16'(k);
         drive_vec({w ^ 16'hD000, w ^ 16'hC000, w ^ 16'hB000, w ^ 16'hA000});
      end
      last = cyc;
      wait_done(at);
      total++;
      if (at != last + 4) begin bad++; $display("FAIL max_done_cyc: got %0d want %0d", at, last + 4); end
`ifdef FEEDER_STALL_CNT_EN
      total++;
      if (stall_cycles !== 8'd0) begin bad++; $display("FAIL max_stall_cnt: got %0d want 0", stall_cycles); end
`endif
      tick();
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL max_done_count: got %0d want 1", done_cnt - d0); end
      for (int r = 0; r < N; r++) begin
         total++;
         if (lane_q[r].size() != 0) begin bad++; $display("FAIL max_lane%0d_left: got %0d pending want 0", r, lane_q[r].size()); end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num_vectors = '0;
      in_data = '0;
      in_valid = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_bubble();
      test_zero_job();
      test_busy_start();
      test_reset_mid_job();
      test_max_count();
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
